// File: rtl/edge_counter_pkg.sv
// Shared constants, dump state encoding and result-word packing for the
// multi-channel edge counter.
package edge_counter_pkg;

  localparam int CMD_START  = 0;
  localparam int CMD_STOP   = 1;
  localparam int CMD_SAVE   = 2;
  localparam int CMD_CLEAR  = 3;
  localparam int CMD_GSTART = 4;

  localparam int MASK_LSB = 16;
  localparam int MASK_MSB = 31;
  localparam int GATE_LSB = 32;
  localparam int GATE_MSB = 63;

  localparam int OUT_OVF_BIT = 32;
  localparam int OUT_CH_LSB  = 40;
  localparam int OUT_CH_MSB  = 43;
  localparam int OUT_TS_LSB  = 64;
  localparam int OUT_TS_MSB  = 127;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DUMP = 1'b1
  } dump_state_e;

  function automatic logic [127:0] pack_word(input logic [31:0] cnt,
                                             input logic        ovf,
                                             input logic [3:0]  ch,
                                             input logic [63:0] ts);
    logic [127:0] w;
    w = '0;
    w[31:0] = cnt;
    w[OUT_OVF_BIT] = ovf;
    w[OUT_CH_MSB:OUT_CH_LSB] = ch;
    w[OUT_TS_MSB:OUT_TS_LSB] = ts;
    return w;
  endfunction

endpackage

// File: rtl/edge_counter_channel.sv
// One counting channel: 2-FF synchroniser, edge register, registered rise
// pulse, and the count/sticky-overflow pair.
module edge_counter_channel #(
  parameter int DATA_WIDTH = 16,
  parameter int SATURATE   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  input_sig,
  input  logic                  enable,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] count,
  output logic                  ovf
);

  logic s1, s2, s3, rise_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1     <= input_sig;
      s2     <= s1;
      s3     <= s2;
      rise_q <= s2 & ~s3;
    end
  end

  // clear wins over a coincident increment
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clear) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (rise_q && enable) begin
      if (count == '1) begin
        ovf   <= 1'b1;
        count <= (SATURATE != 0) ? '1 : '0;
      end else begin
        count <= count + DATA_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/edge_counter_multi.sv
// Multi-channel edge counter: command decode, gate timer, snapshot registers
// and the dump FSM that serialises one result word per channel.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no dump in progress; accepts save / auto-save
//   ST_DUMP | one word written per cycle from the snapshot; saves dropped
module edge_counter_multi
  import edge_counter_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 16,
  parameter int SATURATE   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] input_sig,
  input  logic [63:0]       cmd_in,
  input  logic [63:0]       counter,
  output logic              write,
  output logic [127:0]      count_out,
  output logic              busy,
  output logic              save_drop
);

  logic [15:0]       mask_full;
  logic [NUM_CH-1:0] cmd_mask;
  logic              do_start, do_stop, do_save, do_clear, do_gstart;
  logic              unused_cmd;

  assign mask_full  = cmd_in[MASK_MSB:MASK_LSB];
  assign cmd_mask   = mask_full[NUM_CH-1:0];
  assign do_gstart  = cmd_in[CMD_GSTART];
  assign do_start   = cmd_in[CMD_START] | do_gstart;
  assign do_stop    = cmd_in[CMD_STOP];
  assign do_save    = cmd_in[CMD_SAVE];
  assign do_clear   = cmd_in[CMD_CLEAR];
  assign unused_cmd = ^{cmd_in[MASK_LSB-1:CMD_GSTART+1], mask_full};

  logic              gate_active;
  logic [31:0]       gate_timer;
  logic [NUM_CH-1:0] gate_mask;
  logic              gate_close;

  // A fresh gated start or a stop in the closing cycle pre-empts the auto-save.
  assign gate_close = gate_active && (gate_timer == '0) && !do_gstart && !do_stop;

  logic [NUM_CH-1:0] en_q, en_eff, ch_clear, en_set, en_clr;

  assign en_set   = do_start ? cmd_mask : '0;
  assign en_clr   = (do_stop ? cmd_mask : '0) | (gate_close ? gate_mask : '0);
  assign en_eff   = en_q & ~(gate_close ? gate_mask : '0);
  assign ch_clear = do_clear ? cmd_mask : '0;

  logic [DATA_WIDTH-1:0] cnt [NUM_CH];
  logic [NUM_CH-1:0]     ovf;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    edge_counter_channel #(
      .DATA_WIDTH (DATA_WIDTH),
      .SATURATE   (SATURATE)
    ) u_channel (
      .clk       (clk),
      .reset     (reset),
      .input_sig (input_sig[g]),
      .enable    (en_eff[g]),
      .clear     (ch_clear[g]),
      .count     (cnt[g]),
      .ovf       (ovf[g])
    );
  end

  // start beats stop and gate close
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q <= '0;
    end else begin
      en_q <= (en_q & ~en_clr) | en_set;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gate_active <= 1'b0;
      gate_timer  <= '0;
      gate_mask   <= '0;
    end else if (do_gstart) begin
      gate_active <= 1'b1;
      gate_timer  <= cmd_in[GATE_MSB:GATE_LSB];
      gate_mask   <= cmd_mask;
    end else if (do_stop) begin
      gate_active <= 1'b0;
    end else if (gate_active) begin
      if (gate_timer == '0) begin
        gate_active <= 1'b0;
      end else begin
        gate_timer <= gate_timer - 32'd1;
      end
    end
  end

  logic              save_req;
  logic [NUM_CH-1:0] save_mask;

  assign save_req  = do_save | gate_close;
  assign save_mask = (do_save ? cmd_mask : '0) | (gate_close ? gate_mask : '0);

  logic [DATA_WIDTH-1:0] snap_cnt [NUM_CH];
  logic [NUM_CH-1:0]     snap_ovf;
  logic [63:0]           snap_ts;
  logic [NUM_CH-1:0]     pend;
  dump_state_e           state;

  logic [NUM_CH-1:0]     first_oh, next_oh;
  logic [3:0]            first_idx, next_idx;
  logic [DATA_WIDTH-1:0] first_cnt, next_cnt;
  logic                  first_ovf, next_ovf;

  // Lowest set bit wins: descending scan, last hit kept.
  always_comb begin
    first_oh  = '0;
    first_idx = '0;
    first_cnt = '0;
    first_ovf = 1'b0;
    next_oh   = '0;
    next_idx  = '0;
    next_cnt  = '0;
    next_ovf  = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (save_mask[i]) begin
        first_oh    = '0;
        first_oh[i] = 1'b1;
        first_idx   = 4'(i);
        first_cnt   = cnt[i];
        first_ovf   = ovf[i];
      end
      if (pend[i]) begin
        next_oh    = '0;
        next_oh[i] = 1'b1;
        next_idx   = 4'(i);
        next_cnt   = snap_cnt[i];
        next_ovf   = snap_ovf[i];
      end
    end
  end

  // The first word comes straight from the live (pre-update) registers so it
  // can appear the cycle after the save; later words read the snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      pend      <= '0;
      snap_ovf  <= '0;
      snap_ts   <= '0;
      write     <= 1'b0;
      busy      <= 1'b0;
      save_drop <= 1'b0;
      count_out <= '0;
      for (int i = 0; i < NUM_CH; i++) snap_cnt[i] <= '0;
    end else begin
      write     <= 1'b0;
      save_drop <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (save_req && (save_mask != '0)) begin
            snap_cnt  <= cnt;
            snap_ovf  <= ovf;
            snap_ts   <= counter;
            pend      <= save_mask & ~first_oh;
            write     <= 1'b1;
            busy      <= 1'b1;
            count_out <= pack_word(32'(first_cnt), first_ovf, first_idx, counter);
            state     <= ST_DUMP;
          end
        end
        ST_DUMP: begin
          save_drop <= save_req;
          if (pend != '0) begin
            pend      <= pend & ~next_oh;
            write     <= 1'b1;
            count_out <= pack_word(32'(next_cnt), next_ovf, next_idx, snap_ts);
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          pend  <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
